alu_arbiter: RTL and testbench

//  Shares one `alu` instance between two requesters (e.g. instruction sequencer and test/debug port).

---
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one ALU between two requesters. Each requester hands over one
//   operation with a valid/ready handshake. The block drives the ALU ports,
//   waits LATENCY clocks, and returns the result with a valid/ready handshake.
//   Only one operation is in flight at a time. When both requesters are
//   valid together, the one that was not served last wins.
//
// Parameters
//   WIDTH    data width of ALU operands and result
//   LATENCY  clocks from the op appearing on the ALU ports to valid i_alu_data (>=1)
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_req_valid[k]   requester k presents {op, arg0, arg1}
//   o_req_ready[k]   requester k's operation is taken this cycle (IDLE only)
//   i_req_op         {op1, op0}, 4 bits each
//   i_req_arg0/1     {a1, a0} / {b1, b0}, WIDTH bits each
//   o_rsp_valid[k]   result for requester k is on o_rsp_data
//   i_rsp_ready[k]   requester k takes the result
//   o_rsp_data       result, held while any o_rsp_valid bit is high
//   o_alu_op/arg0/1  to the ALU inputs
//   i_alu_data       from the ALU output
//   o_busy           high whenever an operation is in flight
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [7:0]         i_req_op,
  input  logic [2*WIDTH-1:0] i_req_arg0,
  input  logic [2*WIDTH-1:0] i_req_arg1,
  output logic [1:0]         o_rsp_valid,
  input  logic [1:0]         i_rsp_ready,
  output logic [WIDTH-1:0]   o_rsp_data,
  output logic [3:0]         o_alu_op,
  output logic [WIDTH-1:0]   o_alu_arg0,
  output logic [WIDTH-1:0]   o_alu_arg1,
  input  logic [WIDTH-1:0]   i_alu_data,
  output logic               o_busy
);

  localparam logic [3:0] NO_OP = 4'h0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // The counter only ever holds LATENCY-1 down to 0.
  localparam int             CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic             prio;
  logic             gnt;
  logic [CNT_W-1:0] cnt;

  logic any_valid;
  logic grant;

  // Priority only matters when both requesters are valid; otherwise the
  // single valid requester wins.
  assign any_valid = |i_req_valid;
  assign grant     = (&i_req_valid) ? prio : i_req_valid[1];

  // Ready is combinational from valid and only ever offered in IDLE, so a
  // requester sees exactly one ready cycle per accepted operation.
  assign o_req_ready = (!i_rst && state == S_IDLE && any_valid) ? {grant, ~grant} : 2'b00;
  assign o_busy      = (state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      prio        <= 1'b0;
      gnt         <= 1'b0;
      cnt         <= '0;
      o_rsp_valid <= 2'b00;
      o_rsp_data  <= '0;
      o_alu_op    <= NO_OP;
      o_alu_arg0  <= '0;
      o_alu_arg1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            o_alu_op   <= grant ? i_req_op[7:4] : i_req_op[3:0];
            o_alu_arg0 <= grant ? i_req_arg0[2*WIDTH-1:WIDTH] : i_req_arg0[WIDTH-1:0];
            o_alu_arg1 <= grant ? i_req_arg1[2*WIDTH-1:WIDTH] : i_req_arg1[WIDTH-1:0];
            gnt        <= grant;
            state      <= S_ISSUE;
          end else begin
            o_alu_op <= NO_OP;
          end
        end
        S_ISSUE: begin
          // The op is shown to the ALU for this single cycle; the args stay
          // put afterwards so the ALU inputs do not toggle needlessly.
          o_alu_op <= NO_OP;
          cnt      <= CNT_LOAD;
          if (LATENCY > 1) begin
            state <= S_WAIT;
          end else begin
            state       <= S_RESP;
            o_rsp_data  <= i_alu_data;
            o_rsp_valid <= {gnt, ~gnt};
          end
        end
        S_WAIT: begin
          // Leaving here as the counter reaches zero puts the sampling edge
          // exactly LATENCY clocks after the op reached the ALU.
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state       <= S_RESP;
            o_rsp_data  <= i_alu_data;
            o_rsp_valid <= {gnt, ~gnt};
          end
        end
        S_RESP: begin
          // Only the granted requester's ready completes the response.
          if (i_rsp_ready[gnt]) begin
            o_rsp_valid <= 2'b00;
            prio        <= ~gnt;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. Two instances are exercised:
//   d0 with LATENCY=1 and d1 with LATENCY=3. Each has a small ALU model that
//   presents f(op, arg0, arg1) LATENCY clocks after the op reaches its ports.
//   A transaction-level reference model predicts all DUT outputs every cycle;
//   directed scenarios add hand-computed literal expectations.
module tb_alu_arbiter;

  localparam int W = 16;

  localparam logic [3:0] NO_OP  = 4'h0;
  localparam logic [3:0] ADD_OP = 4'h1;
  localparam logic [3:0] SUB_OP = 4'h2;
  localparam logic [3:0] XOR_OP = 4'h3;
  localparam logic [3:0] OR_OP  = 4'h4;
  localparam logic [3:0] ROL_OP = 4'h5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Stimulus, indexed by instance.
  logic         rst[2];
  logic [1:0]   req_valid[2];
  logic [7:0]   req_op[2];
  logic [2*W-1:0] req_a0[2];
  logic [2*W-1:0] req_a1[2];
  logic [1:0]   rsp_ready[2];

  // Raw DUT outputs.
  logic [1:0]   d0_req_ready, d1_req_ready, d0_rsp_valid, d1_rsp_valid;
  logic [W-1:0] d0_rsp_data, d1_rsp_data, d0_alu_a0, d1_alu_a0, d0_alu_a1, d1_alu_a1;
  logic [3:0]   d0_alu_op, d1_alu_op;
  logic         d0_busy, d1_busy;
  logic [W-1:0] d0_alu_data, d1_alu_data;

  // Indexed views of the DUT outputs.
  logic [1:0]   req_ready[2];
  logic [1:0]   rsp_valid[2];
  logic [W-1:0] rsp_data[2];
  logic [3:0]   alu_op[2];
  logic [W-1:0] alu_a0[2];
  logic [W-1:0] alu_a1[2];
  logic         busy[2];

  always_comb begin
    req_ready[0] = d0_req_ready;  req_ready[1] = d1_req_ready;
    rsp_valid[0] = d0_rsp_valid;  rsp_valid[1] = d1_rsp_valid;
    rsp_data[0]  = d0_rsp_data;   rsp_data[1]  = d1_rsp_data;
    alu_op[0]    = d0_alu_op;     alu_op[1]    = d1_alu_op;
    alu_a0[0]    = d0_alu_a0;     alu_a0[1]    = d1_alu_a0;
    alu_a1[0]    = d0_alu_a1;     alu_a1[1]    = d1_alu_a1;
    busy[0]      = d0_busy;       busy[1]      = d1_busy;
  end

  function automatic logic [W-1:0] alu_f(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      ADD_OP:  return a + b;
      SUB_OP:  return a - b;
      XOR_OP:  return a ^ b;
      OR_OP:   return a | b;
      ROL_OP:  return {a[W-2:0], a[W-1]};
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // ALU models: LATENCY=1 is seen combinationally at the sampling edge;
  // LATENCY=3 passes through two registers, so a one-cycle sampling error
  // picks up the NO_OP result instead.
  logic [W-1:0] pipe1 = '0;
  logic [W-1:0] pipe2 = '0;
  assign d0_alu_data = alu_f(d0_alu_op, d0_alu_a0, d0_alu_a1);
  always @(posedge clk) begin
    pipe1 <= alu_f(d1_alu_op, d1_alu_a0, d1_alu_a1);
    pipe2 <= pipe1;
  end
  assign d1_alu_data = pipe2;

  alu_arbiter #(.WIDTH(W), .LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(d0_req_ready),
    .i_req_op(req_op[0]), .i_req_arg0(req_a0[0]), .i_req_arg1(req_a1[0]),
    .o_rsp_valid(d0_rsp_valid), .i_rsp_ready(rsp_ready[0]), .o_rsp_data(d0_rsp_data),
    .o_alu_op(d0_alu_op), .o_alu_arg0(d0_alu_a0), .o_alu_arg1(d0_alu_a1),
    .i_alu_data(d0_alu_data), .o_busy(d0_busy)
  );

  alu_arbiter #(.WIDTH(W), .LATENCY(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(d1_req_ready),
    .i_req_op(req_op[1]), .i_req_arg0(req_a0[1]), .i_req_arg1(req_a1[1]),
    .o_rsp_valid(d1_rsp_valid), .i_rsp_ready(rsp_ready[1]), .o_rsp_data(d1_rsp_data),
    .o_alu_op(d1_alu_op), .o_alu_arg0(d1_alu_a0), .o_alu_arg1(d1_alu_a1),
    .i_alu_data(d1_alu_data), .o_busy(d1_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Present one operation from requester k of instance d.
  task automatic applyStimulus(input int d, input int k, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[d][k*4 +: 4] = op;
    req_a0[d][k*W +: W] = a;
    req_a1[d][k*W +: W] = b;
    req_valid[d][k]     = 1'b1;
  endtask

  task automatic waitAccept(input int d, input int k, input bit keep, output int c);
    bit found = 1'b0;
    int n = 0;
    c = -1;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (req_ready[d][k]) begin
        found = 1'b1;
        c = cyc;
      end
    end
    if (!found) checkOutput($sformatf("d%0d_accept%0d_timeout", d, k), 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) req_valid[d][k] = 1'b0;
  endtask

  task automatic waitResp(input int d, input int k, output logic [W-1:0] data, output int c);
    bit found = 1'b0;
    int n = 0;
    c = -1;
    data = '0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (rsp_valid[d][k] && rsp_ready[d][k]) begin
        found = 1'b1;
        c = cyc;
        data = rsp_data[d];
      end
    end
    if (!found) checkOutput($sformatf("d%0d_resp%0d_timeout", d, k), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Reference model: per instance, whether an op is in flight, how many
  // edges have passed since it was accepted, who owns it and its result.
  bit           m_busy[2];
  int           m_age[2];
  bit           m_who[2];
  bit           m_prio[2];
  logic [3:0]   m_op[2];
  logic [W-1:0] m_arg0[2];
  logic [W-1:0] m_arg1[2];
  logic [W-1:0] m_res[2];
  logic [W-1:0] m_last[2];
  int           op_cnt[2];
  int           req1_act;

  initial begin
    logic [1:0] exp_ready;
    logic [1:0] exp_valid;
    logic [3:0] exp_op;
    bit g;
    bit in_resp;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_age[d] = 0; m_who[d] = 0; m_prio[d] = 0; m_op[d] = NO_OP;
      m_arg0[d] = '0; m_arg1[d] = '0; m_res[d] = '0; m_last[d] = '0; op_cnt[d] = 0;
    end
    req1_act = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int d = 0; d < 2; d++) begin
          if (rst[d]) begin
            checkOutput($sformatf("d%0d_rst_ready", d), req_ready[d], 32'd0);
            checkOutput($sformatf("d%0d_rst_valid", d), rsp_valid[d], 32'd0);
            checkOutput($sformatf("d%0d_rst_data", d), rsp_data[d], 32'd0);
            checkOutput($sformatf("d%0d_rst_op", d), alu_op[d], NO_OP);
            checkOutput($sformatf("d%0d_rst_args", d), {alu_a1[d], alu_a0[d]}, 32'd0);
            checkOutput($sformatf("d%0d_rst_busy", d), busy[d], 32'd0);
            m_busy[d] = 0; m_prio[d] = 0; m_last[d] = '0; m_arg0[d] = '0; m_arg1[d] = '0;
          end else begin
            in_resp   = m_busy[d] && (m_age[d] > lat_of(d));
            g         = (&req_valid[d]) ? m_prio[d] : req_valid[d][1];
            exp_ready = (!m_busy[d] && |req_valid[d]) ? (g ? 2'b10 : 2'b01) : 2'b00;
            exp_valid = in_resp ? (m_who[d] ? 2'b10 : 2'b01) : 2'b00;
            exp_op    = (m_busy[d] && m_age[d] == 1) ? m_op[d] : NO_OP;
            checkOutput($sformatf("d%0d_req_ready", d), req_ready[d], exp_ready);
            checkOutput($sformatf("d%0d_rsp_valid", d), rsp_valid[d], exp_valid);
            checkOutput($sformatf("d%0d_rsp_data", d), rsp_data[d], m_last[d]);
            checkOutput($sformatf("d%0d_alu_op", d), alu_op[d], exp_op);
            checkOutput($sformatf("d%0d_alu_args", d), {alu_a1[d], alu_a0[d]}, {m_arg1[d], m_arg0[d]});
            checkOutput($sformatf("d%0d_busy", d), busy[d], m_busy[d]);
            // Advance the model across the coming clock edge.
            if (!m_busy[d]) begin
              if (|req_valid[d]) begin
                m_busy[d] = 1; m_age[d] = 1; m_who[d] = g;
                m_op[d]   = g ? req_op[d][7:4] : req_op[d][3:0];
                m_arg0[d] = g ? req_a0[d][2*W-1:W] : req_a0[d][W-1:0];
                m_arg1[d] = g ? req_a1[d][2*W-1:W] : req_a1[d][W-1:0];
                m_res[d]  = alu_f(m_op[d], m_arg0[d], m_arg1[d]);
              end
            end else if (in_resp) begin
              if (rsp_ready[d][m_who[d]]) begin
                m_busy[d] = 0;
                m_prio[d] = !m_who[d];
              end
            end else begin
              m_age[d]++;
              if (m_age[d] == lat_of(d) + 1) m_last[d] = m_res[d];
            end
          end
          if (alu_op[d] != NO_OP) op_cnt[d]++;
        end
        if (req_ready[0][1] || rsp_valid[0][1]) req1_act++;
      end
    end
  end

  logic [3:0]   t6_op[4]  = '{ADD_OP, SUB_OP, XOR_OP, ROL_OP};
  logic [W-1:0] t6_a[4]   = '{16'hFFFF, 16'h0000, 16'h5A5A, 16'h8000};
  logic [W-1:0] t6_b[4]   = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000};
  logic [W-1:0] t6_exp[4] = '{16'h0000, 16'hFFFF, 16'hA5A5, 16'h0001};

  // Directed scenarios.
  initial begin
    int ca, ca0, ca1, cr, c0, hs, snap_op, snap_act;
    int t6_acc[4];
    logic [W-1:0] data;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 2'b00; req_op[d] = '0;
      req_a0[d] = '0; req_a1[d] = '0; rsp_ready[d] = 2'b11;
    end
    repeat (3) @(posedge clk);
    #1;

    // Ready must stay low while reset is held, even with a valid request.
    applyStimulus(0, 0, ADD_OP, 16'd5, 16'd8);
    @(negedge clk);
    checkOutput("rst_hold_ready", req_ready[0], 32'd0);
    checkOutput("rst_hold_busy", busy[0], 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    $display("[TB] single ADD on requester 0");
    waitAccept(0, 0, 1'b0, ca);
    waitResp(0, 0, data, cr);
    checkOutput("t1_data", data, 16'd13);
    checkOutput("t1_latency", cr - ca, 32'd2);

    $display("[TB] simultaneous requests, round-robin");
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    applyStimulus(0, 0, SUB_OP, 16'd8, 16'd13);
    applyStimulus(0, 1, XOR_OP, 16'hCACA, 16'hACAC);
    c0 = cyc;
    waitAccept(0, 0, 1'b0, ca0);
    checkOutput("t2_first_req0", ca0, c0);
    waitResp(0, 0, data, cr);
    checkOutput("t2_req0_data", data, 16'hFFFB);
    waitAccept(0, 1, 1'b0, ca1);
    waitResp(0, 1, data, cr);
    checkOutput("t2_req1_data", data, 16'h6666);
    applyStimulus(0, 0, ADD_OP, 16'd1, 16'd2);
    waitAccept(0, 0, 1'b0, ca);
    waitResp(0, 0, data, cr);
    checkOutput("t2_single_data", data, 16'd3);
    applyStimulus(0, 0, ADD_OP, 16'h1111, 16'h2222);
    applyStimulus(0, 1, SUB_OP, 16'h0005, 16'h0007);
    c0 = cyc;
    waitAccept(0, 1, 1'b0, ca1);
    checkOutput("t2_first_req1", ca1, c0);
    waitResp(0, 1, data, cr);
    checkOutput("t2b_req1_data", data, 16'hFFFE);
    waitAccept(0, 0, 1'b0, ca0);
    waitResp(0, 0, data, cr);
    checkOutput("t2b_req0_data", data, 16'h3333);

    $display("[TB] response backpressure on requester 1");
    rsp_ready[0] = 2'b01;
    applyStimulus(0, 1, ADD_OP, 16'd100, 16'd23);
    waitAccept(0, 1, 1'b0, ca);
    applyStimulus(0, 0, OR_OP, 16'h00F0, 16'h0F00);
    begin
      int n = 0;
      while (!rsp_valid[0][1] && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!rsp_valid[0][1]) checkOutput("t3_valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("t3_hold_valid", rsp_valid[0], 32'b10);
      checkOutput("t3_hold_data", rsp_data[0], 16'd123);
      checkOutput("t3_hold_ready", req_ready[0], 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 2'b11;
    waitResp(0, 1, data, hs);
    checkOutput("t3_data", data, 16'd123);
    waitAccept(0, 0, 1'b0, ca);
    checkOutput("t3_grant_after_hs", ca, hs + 1);
    waitResp(0, 0, data, cr);
    checkOutput("t3_req0_data", data, 16'h0FF0);

    $display("[TB] back-to-back on requester 0");
    snap_act = req1_act;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, t6_op[i], t6_a[i], t6_b[i]);
      waitAccept(0, 0, (i < 3), t6_acc[i]);
      waitResp(0, 0, data, cr);
      checkOutput($sformatf("t6_data%0d", i), data, t6_exp[i]);
      if (i > 0) checkOutput($sformatf("t6_spacing%0d", i), t6_acc[i] - t6_acc[i-1], 32'd3);
    end
    checkOutput("t6_req1_quiet", req1_act - snap_act, 32'd0);

    $display("[TB] ROL with LATENCY=3");
    snap_op = op_cnt[1];
    applyStimulus(1, 0, ROL_OP, 16'h9A9A, 16'h1234);
    waitAccept(1, 0, 1'b0, ca);
    waitResp(1, 0, data, cr);
    checkOutput("t5_data", data, 16'h3535);
    checkOutput("t5_latency", cr - ca, 32'd4);
    checkOutput("t5_op_cycles", op_cnt[1] - snap_op, 32'd1);

    $display("[TB] reset during WAIT");
    applyStimulus(1, 1, ADD_OP, 16'd7, 16'd9);
    waitAccept(1, 1, 1'b0, ca);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    checkOutput("t4_busy_now", busy[1], 32'd0);
    checkOutput("t4_op_now", alu_op[1], NO_OP);
    checkOutput("t4_valid_now", rsp_valid[1], 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t4_no_resp", rsp_valid[1], 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1, 0, ADD_OP, 16'd2, 16'd3);
    applyStimulus(1, 1, SUB_OP, 16'd20, 16'd5);
    c0 = cyc;
    waitAccept(1, 0, 1'b0, ca0);
    checkOutput("t4_prio_reset", ca0, c0);
    waitResp(1, 0, data, cr);
    checkOutput("t4_req0_data", data, 16'd5);
    waitAccept(1, 1, 1'b0, ca1);
    waitResp(1, 1, data, cr);
    checkOutput("t4_req1_data", data, 16'd15);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
